cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 6, SHALL set the number of functional-unit requesters on the common data bus; legal range 2..8.
REQ-002 Parameter TAG_W, default 3, SHALL set the width of the ROB tag carried with each result.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 flush_ip  in  1  SHALL indicate a pipeline flush is in progress.
REQ-006 req_i  in  N_REQ  SHALL carry per-requester result-valid; bit i is requester i.
REQ-007 tag_i  in  N_REQ*TAG_W  SHALL carry per-requester ROB tags; slice i is [i*TAG_W +: TAG_W].
REQ-008 data_i  in  N_REQ*32  SHALL carry per-requester result data; slice i is [i*32 +: 32].
REQ-009 gnt_o  out  N_REQ  SHALL be a one-hot-or-zero grant; requester i's result is taken this cycle when gnt_o[i]=1.
REQ-010 cdb_ready_i  in  1  SHALL indicate the ROB/regfile/stations consume the current CDB broadcast this cycle.
REQ-011 cdb_valid_o  out  1  SHALL indicate a valid registered broadcast on the CDB.
REQ-012 cdb_tag_o  out  TAG_W  SHALL be the broadcast ROB tag.
REQ-013 cdb_data_o  out  32  SHALL be the broadcast result data.
REQ-014 cdb_src_o  out  3  SHALL be the index of the requester that produced the broadcast.

Function
REQ-015 The output stage SHALL be able to accept (accept=1) when cdb_valid_o=0 or cdb_ready_i=1.
REQ-016 gnt_o SHALL be combinational from req_i, the round-robin pointer, accept and flush_ip; it is all-zero when accept=0, flush_ip=1 or req_i=0.
REQ-017 When granting, the block SHALL select the first set req_i bit at or after pointer index p, scanning p, p+1, ... and wrapping from N_REQ-1 to 0.
REQ-018 On a grant to index k, the pointer SHALL update to k+1 on the next edge, wrapping to 0 when k=N_REQ-1; with no grant it SHALL hold.
REQ-019 On a grant to k, the next edge SHALL load cdb_valid_o=1, cdb_tag_o=tag_i[k], cdb_data_o=data_i[k] and cdb_src_o=k (one-cycle latency).
REQ-020 With accept=1 and no grant, cdb_valid_o SHALL load 0; tag, data and src SHALL hold.
REQ-021 With accept=0, all output registers SHALL hold; a stalled broadcast SHALL never change until consumed.
REQ-022 Requesters SHALL hold req_i, tag_i and data_i stable until granted; the arbiter SHALL NOT grant a requester twice for one result.
REQ-023 Back-to-back throughput SHALL be one broadcast per cycle while cdb_ready_i=1.
REQ-024 Fairness: a requester holding req_i asserted SHALL be granted within N_REQ consecutive accept cycles.
REQ-025 flush_ip=1 SHALL suppress all grants and load cdb_valid_o=0 on the next edge regardless of cdb_ready_i; the pointer SHALL hold.
REQ-026 A simultaneous grant and consume SHALL replace the broadcast in the same edge without a bubble.

Reset
REQ-027 On rst=1 at an edge: cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0, cdb_src_o=0, pointer=0.
REQ-028 While rst=1, gnt_o SHALL be all-zero.
REQ-029 rst SHALL take precedence over flush_ip and any pending grant; an in-flight broadcast is discarded.

Verification
REQ-030 Reset, then req_i=6'b000100, tag_i[2]=3'd5, data_i[2]=32'hDEAD_BEEF, cdb_ready_i=1 -> gnt_o=6'b000100 the same cycle; next cycle valid=1, tag=5, data=DEADBEEF, src=2.
REQ-031 req_i=6'b111111 held for 6 cycles, ready=1 -> grants in order 0,1,2,3,4,5; the 7th cycle grants 0 again.
REQ-032 Broadcast from requester 1 valid and cdb_ready_i=0 for 3 cycles while req_i=6'b001000 -> gnt_o=0 and outputs stable for 3 cycles; with ready=1, grant to 3 and the next cycle src=3.
REQ-033 Pointer=4, req_i=6'b000011 -> the scan wraps and grants index 0; pointer becomes 1.
REQ-034 cdb_valid_o=1, cdb_ready_i=0, flush_ip=1, req_i=6'b100000 -> gnt_o=0; next cycle cdb_valid_o=0; pointer unchanged.
REQ-035 rst asserted with a broadcast held and req_i=6'b010000 -> gnt_o=0; next cycle all outputs 0 and pointer 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the common data bus (CDB). Functional units raise
// req_i with a ROB tag and a 32-bit result. One requester is granted per cycle
// and its result is registered onto the CDB one edge later. A broadcast that
// is not consumed (cdb_ready_i=0) stalls and stays stable until it is.
//
// Handshake: a requester's result is taken in the cycle gnt_o[i]=1. The CDB
// output is a valid/ready register: the broadcast is consumed in a cycle where
// cdb_valid_o=1 and cdb_ready_i=1, and it never changes while valid and not
// consumed (except on flush or reset, which discard it).
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   TAG_W  ROB tag width
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_ip      pipeline flush: suppress grants, drop the broadcast
//   req_i         per-requester result valid
//   tag_i         per-requester ROB tag, slice i = [i*TAG_W +: TAG_W]
//   data_i        per-requester result, slice i = [i*32 +: 32]
//   gnt_o         one-hot-or-zero grant (combinational)
//   cdb_ready_i   consumers take the current broadcast this cycle
//   cdb_valid_o   registered broadcast valid
//   cdb_tag_o     broadcast ROB tag
//   cdb_data_o    broadcast result data
//   cdb_src_o     index of the requester that produced the broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_REQ = 6,
  parameter int TAG_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_ip,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*TAG_W-1:0] tag_i,
  input  logic [N_REQ*32-1:0]    data_i,
  output logic [N_REQ-1:0]       gnt_o,
  input  logic                   cdb_ready_i,
  output logic                   cdb_valid_o,
  output logic [TAG_W-1:0]       cdb_tag_o,
  output logic [31:0]            cdb_data_o,
  output logic [2:0]             cdb_src_o
);

  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  logic [2:0]       ptr_q, ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_data_q, cdb_data_d;
  logic [2:0]       cdb_src_q, cdb_src_d;

  logic             accept;
  logic             grant;
  logic [2:0]       gnt_idx;
  logic [N_REQ-1:0] gnt;

  // Output register can take a new value when empty or being consumed.
  assign accept = !cdb_valid_q || cdb_ready_i;

  // Round-robin scan starting at the pointer; first set request wins.
  // The pointer always stays below N_REQ, so the modulo only handles wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    grant   = 1'b0;
    if (accept && !flush_ip && !rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant && req_i[(int'(ptr_q) + i) % N_REQ]) begin
          grant   = 1'b1;
          gnt_idx = 3'((int'(ptr_q) + i) % N_REQ);
          gnt[(int'(ptr_q) + i) % N_REQ] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant) begin
      ptr_d = (gnt_idx == LAST_IDX) ? 3'd0 : gnt_idx + 3'd1;
    end
    if (flush_ip) begin
      // Flush drops the broadcast even if it is stalled; payload holds.
      cdb_valid_d = 1'b0;
    end else if (accept) begin
      if (grant) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = tag_i[int'(gnt_idx)*TAG_W +: TAG_W];
        cdb_data_d  = data_i[int'(gnt_idx)*32 +: 32];
        cdb_src_d   = gnt_idx;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign gnt_o       = gnt;
  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter (N_REQ=6, TAG_W=3). A reference model tracks the
// round-robin pointer and the output register; expected broadcasts are pushed
// to exp_q when a grant is predicted and popped when the CDB loads them.
// Directed scenarios add constant expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N  = 6;
  localparam int TW = 3;
  localparam int W  = 3 + TW + 32;

  logic            clk;
  logic            rst;
  logic            flush_ip;
  logic [N-1:0]    req_i;
  logic [N*TW-1:0] tag_i;
  logic [N*32-1:0] data_i;
  logic [N-1:0]    gnt_o;
  logic            cdb_ready_i;
  logic            cdb_valid_o;
  logic [TW-1:0]   cdb_tag_o;
  logic [31:0]     cdb_data_o;
  logic [2:0]      cdb_src_o;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_ip   (flush_ip),
    .req_i      (req_i),
    .tag_i      (tag_i),
    .data_i     (data_i),
    .gnt_o      (gnt_o),
    .cdb_ready_i(cdb_ready_i),
    .cdb_valid_o(cdb_valid_o),
    .cdb_tag_o  (cdb_tag_o),
    .cdb_data_o (cdb_data_o),
    .cdb_src_o  (cdb_src_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] tags [N];
  logic [31:0]   datas[N];
  int            m_ptr   = 0;
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_out   = '0;
  logic [N-1:0]  last_gnt;

  function automatic int scan(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check grant, clock, check CDB outputs.
  task automatic cycle(input logic [N-1:0] req, input logic rdy,
                       input logic fl, input logic rs);
    logic         acc;
    int           k;
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) begin
      tag_i[i*TW +: TW]  = tags[i];
      data_i[i*32 +: 32] = datas[i];
    end
    req_i = req; cdb_ready_i = rdy; flush_ip = fl; rst = rs;
    #1;
    acc = !m_valid || rdy;
    k   = (rs || fl || !acc) ? -1 : scan(req, m_ptr);
    eg  = '0;
    if (k >= 0) eg[k] = 1'b1;
    checks++;
    if (gnt_o !== eg) begin
      errors++;
      $display("FAIL gnt: got %b expected %b", gnt_o, eg);
    end
    last_gnt = gnt_o;
    if (k >= 0) begin
      exp_q.push_back({3'(k), tags[k], datas[k]});
      m_ptr = (k + 1) % N;
    end
    @(posedge clk);
    #1;
    if (rs) begin
      m_valid = 1'b0; m_out = '0; m_ptr = 0; exp_q.delete();
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      if (k >= 0) begin
        m_valid = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
          m_out = exp_q.pop_front();
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    checks++;
    if (cdb_valid_o !== m_valid) begin
      errors++;
      $display("FAIL valid: got %b expected %b", cdb_valid_o, m_valid);
    end
    checks++;
    if ({cdb_src_o, cdb_tag_o, cdb_data_o} !== m_out) begin
      errors++;
      $display("FAIL payload: got src=%0d tag=%0d data=%h expected src=%0d tag=%0d data=%h",
               cdb_src_o, cdb_tag_o, cdb_data_o,
               m_out[W-1 -: 3], m_out[32 +: TW], m_out[31:0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cycle(6'b111111, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({cdb_valid_o, cdb_src_o, cdb_tag_o, cdb_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b src=%0d tag=%0d data=%h expected all 0",
               cdb_valid_o, cdb_src_o, cdb_tag_o, cdb_data_o);
    end
  endtask

  task automatic test_single();
    tags[2] = 3'd5; datas[2] = 32'hDEAD_BEEF;
    cycle(6'b000100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_gnt !== 6'b000100) begin
      errors++; $display("FAIL single_gnt: got %b expected 000100", last_gnt);
    end
    checks++;
    if (cdb_valid_o !== 1'b1 || cdb_tag_o !== 3'd5 || cdb_data_o !== 32'hDEAD_BEEF ||
        cdb_src_o !== 3'd2) begin
      errors++;
      $display("FAIL single_bcast: got v=%b tag=%0d data=%h src=%0d expected 1 5 deadbeef 2",
               cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    cycle(6'b000000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(6'b111111, 1'b1, 1'b0, 1'b0);
      e = '0; e[i % N] = 1'b1;
      checks++;
      if (last_gnt !== e) begin
        errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, last_gnt, e);
      end
      checks++;
      if (cdb_src_o !== 3'(i % N) || cdb_valid_o !== 1'b1) begin
        errors++; $display("FAIL rr_src[%0d]: got %0d expected %0d", i, cdb_src_o, i % N);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    cycle(6'b000010, 1'b1, 1'b0, 1'b0);  // pointer at 1 -> grant 1
    held = cdb_data_o;
    for (int i = 0; i < 3; i++) begin
      cycle(6'b001000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (last_gnt !== '0 || cdb_src_o !== 3'd1 || cdb_valid_o !== 1'b1 ||
          cdb_data_o !== held) begin
        errors++;
        $display("FAIL stall[%0d]: got gnt=%b src=%0d v=%b data=%h expected 0 1 1 %h",
                 i, last_gnt, cdb_src_o, cdb_valid_o, cdb_data_o, held);
      end
    end
    cycle(6'b001000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_gnt !== 6'b001000 || cdb_src_o !== 3'd3) begin
      errors++;
      $display("FAIL stall_release: got gnt=%b src=%0d expected 001000 3", last_gnt, cdb_src_o);
    end
  endtask

  task automatic test_wrap();
    cycle(6'b000011, 1'b1, 1'b0, 1'b0);  // pointer at 4 -> wraps to 0
    checks++;
    if (last_gnt !== 6'b000001) begin
      errors++; $display("FAIL wrap: got %b expected 000001", last_gnt);
    end
    cycle(6'b000011, 1'b1, 1'b0, 1'b0);  // pointer now 1
    checks++;
    if (last_gnt !== 6'b000010) begin
      errors++; $display("FAIL wrap_ptr: got %b expected 000010", last_gnt);
    end
  endtask

  task automatic test_flush();
    cycle(6'b100000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (last_gnt !== '0 || cdb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush: got gnt=%b v=%b expected 000000 0", last_gnt, cdb_valid_o);
    end
    cycle(6'b111111, 1'b1, 1'b0, 1'b0);  // pointer held at 2
    checks++;
    if (last_gnt !== 6'b000100) begin
      errors++; $display("FAIL flush_ptr: got %b expected 000100", last_gnt);
    end
  endtask

  task automatic test_reset_precedence();
    cycle(6'b010000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (last_gnt !== '0 ||
        {cdb_valid_o, cdb_src_o, cdb_tag_o, cdb_data_o} !== '0) begin
      errors++;
      $display("FAIL rst_prec: got gnt=%b v=%b src=%0d tag=%0d data=%h expected all 0",
               last_gnt, cdb_valid_o, cdb_src_o, cdb_tag_o, cdb_data_o);
    end
    cycle(6'b111111, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_gnt !== 6'b000001) begin
      errors++; $display("FAIL rst_ptr: got %b expected 000001", last_gnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        tags[i]  = TW'($urandom_range(0, 7));
        datas[i] = $urandom;
      end
      cycle(N'($urandom_range(0, 63)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'b0);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; flush_ip = 1'b0; req_i = '0; cdb_ready_i = 1'b0;
    tag_i = '0; data_i = '0;
    for (int i = 0; i < N; i++) begin
      tags[i]  = TW'(i + 1);
      datas[i] = 32'h1000_0000 + 32'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_flush();
    test_reset_precedence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
